// File: rtl/caliptra_fpga_clk_stepper.sv
// Multi-channel gated-clock step controller: turns STOP/STEP/RUN/CLR_CYC commands
// into registered per-channel clock enables with cycle counters and sticky status.
module caliptra_fpga_clk_stepper #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int TS_W   = 64
) (
  input  logic                     aclk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [NUM_CH-1:0]        cmd_ch_mask,
  input  logic [1:0]               cmd_op,
  input  logic [CNT_W-1:0]         cmd_count,
  input  logic [NUM_CH-1:0]        brk_i,
  input  logic                     err_clr_i,
  output logic [NUM_CH-1:0]        clk_en_o,
  output logic [NUM_CH-1:0]        busy_o,
  output logic [NUM_CH*CNT_W-1:0]  remaining_o,
  output logic [NUM_CH*TS_W-1:0]   cycles_o,
  output logic [NUM_CH-1:0]        done_o,
  output logic [NUM_CH-1:0]        brk_hit_o,
  output logic                     err_o,
  output logic [2*NUM_CH-1:0]      dbg_state
);

  // Command handshake: a command is taken on any posedge where cmd_valid && cmd_ready.
  // cmd_ready never looks at cmd_valid; it drops while any channel's pending slot is full.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_RUN  = 2'd2
  } ch_state_e;

  localparam logic [1:0] OP_STOP = 2'd0;
  localparam logic [1:0] OP_STEP = 2'd1;
  localparam logic [1:0] OP_RUN  = 2'd2;
  localparam logic [1:0] OP_CLR  = 2'd3;

  ch_state_e          st_q   [NUM_CH];
  ch_state_e          st_d   [NUM_CH];
  logic [CNT_W-1:0]   rem_q  [NUM_CH];
  logic [CNT_W-1:0]   rem_d  [NUM_CH];
  logic [CNT_W-1:0]   pcnt_q [NUM_CH];
  logic [CNT_W-1:0]   pcnt_d [NUM_CH];
  logic [TS_W-1:0]    cyc_q  [NUM_CH];
  logic [TS_W-1:0]    cyc_d  [NUM_CH];
  logic [NUM_CH-1:0]  pv_q, pv_d;
  logic [NUM_CH-1:0]  en_d, done_d, hit_d;
  logic               cmd_fire, step_zero, cmd_legal, err_d;

  assign cmd_ready = !rst && !(|pv_q);
  assign cmd_fire  = cmd_valid && cmd_ready;
  // A zero-length STEP is rejected as a whole, for every channel in the mask.
  assign step_zero = cmd_fire && (cmd_op == OP_STEP) && (cmd_count == '0);
  assign cmd_legal = cmd_fire && !step_zero;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      st_d[c]   = st_q[c];
      rem_d[c]  = rem_q[c];
      pcnt_d[c] = pcnt_q[c];
      pv_d[c]   = pv_q[c];
      done_d[c] = 1'b0;
      hit_d[c]  = brk_hit_o[c];
      cyc_d[c]  = clk_en_o[c] ? cyc_q[c] + TS_W'(1) : cyc_q[c];

      // Countdown; on the last enabled cycle a pending count chains in without a gap.
      if (st_q[c] == ST_STEP) begin
        if (rem_q[c] != '0) begin
          rem_d[c] = rem_q[c] - CNT_W'(1);
        end else if (pv_q[c]) begin
          rem_d[c] = pcnt_q[c] - CNT_W'(1);
          pv_d[c]  = 1'b0;
        end else begin
          st_d[c]   = ST_IDLE;
          done_d[c] = 1'b1;
        end
      end

      if (cmd_legal && cmd_ch_mask[c]) begin
        unique case (cmd_op)
          OP_STOP: begin
            hit_d[c] = 1'b0;
            if (st_q[c] != ST_IDLE) begin
              st_d[c]   = ST_IDLE;
              rem_d[c]  = '0;
              pv_d[c]   = 1'b0;
              done_d[c] = 1'b1;
            end
          end
          OP_STEP: begin
            hit_d[c] = 1'b0;
            if (st_q[c] == ST_STEP && rem_q[c] != '0) begin
              pv_d[c]   = 1'b1;
              pcnt_d[c] = cmd_count;
            end else begin
              st_d[c]   = ST_STEP;
              rem_d[c]  = cmd_count - CNT_W'(1);
              pv_d[c]   = 1'b0;
              done_d[c] = 1'b0;
            end
          end
          OP_RUN: begin
            hit_d[c]  = 1'b0;
            st_d[c]   = ST_RUN;
            rem_d[c]  = '0;
            pv_d[c]   = 1'b0;
            done_d[c] = 1'b0;
          end
          OP_CLR: begin
            cyc_d[c] = '0;
          end
          default: ;
        endcase
      end else if (brk_i[c] && st_q[c] != ST_IDLE) begin
        st_d[c]   = ST_IDLE;
        rem_d[c]  = '0;
        pv_d[c]   = 1'b0;
        done_d[c] = 1'b1;
        hit_d[c]  = 1'b1;
      end

      en_d[c] = (st_d[c] != ST_IDLE);
    end
  end

  // Set wins over clear.
  always_comb begin
    err_d = err_o;
    if (step_zero) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c]   <= ST_IDLE;
        rem_q[c]  <= '0;
        pcnt_q[c] <= '0;
        cyc_q[c]  <= '0;
      end
      pv_q      <= '0;
      clk_en_o  <= '0;
      done_o    <= '0;
      brk_hit_o <= '0;
      err_o     <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c]   <= st_d[c];
        rem_q[c]  <= rem_d[c];
        pcnt_q[c] <= pcnt_d[c];
        cyc_q[c]  <= cyc_d[c];
      end
      pv_q      <= pv_d;
      clk_en_o  <= en_d;
      done_o    <= done_d;
      brk_hit_o <= hit_d;
      err_o     <= err_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign busy_o[g]                     = (st_q[g] != ST_IDLE);
    assign remaining_o[g*CNT_W +: CNT_W] = rem_q[g];
    assign cycles_o[g*TS_W +: TS_W]      = cyc_q[g];
    assign dbg_state[g*2 +: 2]           = st_q[g];
  end

endmodule

// File: tb/tb_caliptra_fpga_clk_stepper.sv
// Bench for caliptra_fpga_clk_stepper: two channels, narrow cycle counter so wrap is reachable.
module tb_caliptra_fpga_clk_stepper;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 16;
  localparam int TS_W   = 8;

  logic                    aclk = 1'b0;
  logic                    rst;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [NUM_CH-1:0]       cmd_ch_mask;
  logic [1:0]              cmd_op;
  logic [CNT_W-1:0]        cmd_count;
  logic [NUM_CH-1:0]       brk_i;
  logic                    err_clr_i;
  logic [NUM_CH-1:0]       clk_en_o;
  logic [NUM_CH-1:0]       busy_o;
  logic [NUM_CH*CNT_W-1:0] remaining_o;
  logic [NUM_CH*TS_W-1:0]  cycles_o;
  logic [NUM_CH-1:0]       done_o;
  logic [NUM_CH-1:0]       brk_hit_o;
  logic                    err_o;
  logic [2*NUM_CH-1:0]     dbg_state;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [CNT_W-1:0] exp_q[$];
  logic [TS_W-1:0]  cyc_exp_q[$];
  logic [CNT_W-1:0] exp_rem;
  logic [TS_W-1:0]  exp_cyc;

  caliptra_fpga_clk_stepper #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TS_W(TS_W)) dut (
    .aclk(aclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch_mask(cmd_ch_mask), .cmd_op(cmd_op), .cmd_count(cmd_count),
    .brk_i(brk_i), .err_clr_i(err_clr_i), .clk_en_o(clk_en_o), .busy_o(busy_o),
    .remaining_o(remaining_o), .cycles_o(cycles_o), .done_o(done_o),
    .brk_hit_o(brk_hit_o), .err_o(err_o), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_cmd(input logic [NUM_CH-1:0] mask, input logic [1:0] op,
                          input logic [CNT_W-1:0] cnt);
    int n;
    cmd_valid   = 1'b1;
    cmd_ch_mask = mask;
    cmd_op      = op;
    cmd_count   = cnt;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    vec_cnt++;
    if (cmd_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL cmd_ready_wait: got %b want 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    vec_cnt++;
    if (cmd_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    vec_cnt++;
    if ({clk_en_o, busy_o, done_o, brk_hit_o, err_o} !== '0) begin
      err_cnt++; $display("FAIL rst_flags: got %b want 0", {clk_en_o, busy_o, done_o, brk_hit_o, err_o});
    end
    vec_cnt++;
    if ({remaining_o, cycles_o} !== '0) begin
      err_cnt++; $display("FAIL rst_counts: got %h want 0", {remaining_o, cycles_o});
    end
    rst = 1'b0;
    tick();
    vec_cnt++;
    if (cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_step();
    for (int i = 4; i >= 0; i--) exp_q.push_back(CNT_W'(i));
    send_cmd(2'b01, 2'd1, 16'd5);
    for (int k = 0; k < 5; k++) begin
      exp_rem = exp_q.pop_front();
      vec_cnt++;
      if (clk_en_o !== 2'b01 || done_o !== 2'b00) begin
        err_cnt++; $display("FAIL step_en k=%0d: en=%b done=%b want en=01 done=00", k, clk_en_o, done_o);
      end
      vec_cnt++;
      if (remaining_o[CNT_W-1:0] !== exp_rem) begin
        err_cnt++; $display("FAIL step_rem k=%0d: got %0d want %0d", k, remaining_o[CNT_W-1:0], exp_rem);
      end
      tick();
    end
    vec_cnt++;
    if (clk_en_o !== 2'b00 || done_o !== 2'b01 || busy_o !== 2'b00) begin
      err_cnt++; $display("FAIL step_end: en=%b done=%b busy=%b want 00/01/00", clk_en_o, done_o, busy_o);
    end
    vec_cnt++;
    if (cycles_o[TS_W-1:0] !== 8'd5 || cycles_o[2*TS_W-1:TS_W] !== 8'd0) begin
      err_cnt++; $display("FAIL step_cycles: ch0=%0d ch1=%0d want 5/0", cycles_o[TS_W-1:0], cycles_o[2*TS_W-1:TS_W]);
    end
    tick();
    vec_cnt++;
    if (done_o !== 2'b00) begin err_cnt++; $display("FAIL step_done_pulse: got %b want 00", done_o); end
  endtask

  task automatic test_chain();
    cmd_valid = 1'b1; cmd_ch_mask = 2'b01; cmd_op = 2'd1; cmd_count = 16'd3;
    exp_q.push_back(16'd2); exp_q.push_back(16'd1); exp_q.push_back(16'd0);
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) begin
        cmd_valid = 1'b1; cmd_count = 16'd2;
        exp_q.push_back(16'd1); exp_q.push_back(16'd0);
      end else if (k == 2) begin
        vec_cnt++;
        if (cmd_ready !== 1'b0) begin err_cnt++; $display("FAIL chain_ready_full: got %b want 0", cmd_ready); end
        cmd_valid = 1'b1; cmd_count = 16'd1;
        exp_q.push_back(16'd0);
      end else if (k == 3) begin
        vec_cnt++;
        if (cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL chain_ready_free: got %b want 1", cmd_ready); end
        cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      exp_rem = exp_q.pop_front();
      vec_cnt++;
      if (clk_en_o[0] !== 1'b1 || done_o[0] !== 1'b0 || remaining_o[CNT_W-1:0] !== exp_rem) begin
        err_cnt++;
        $display("FAIL chain_cycle k=%0d: en=%b done=%b rem=%0d want 1/0/%0d",
                 k, clk_en_o[0], done_o[0], remaining_o[CNT_W-1:0], exp_rem);
      end
      tick();
    end
    cmd_valid = 1'b0;
    vec_cnt++;
    if (clk_en_o[0] !== 1'b0 || done_o[0] !== 1'b1 || exp_q.size() != 0) begin
      err_cnt++; $display("FAIL chain_end: en=%b done=%b left=%0d want 0/1/0", clk_en_o[0], done_o[0], exp_q.size());
    end
    tick();
  endtask

  task automatic test_run_brk();
    send_cmd(2'b11, 2'd2, 16'd0);
    for (int k = 1; k < 10; k++) tick();
    vec_cnt++;
    if (clk_en_o !== 2'b11 || remaining_o !== '0 || busy_o !== 2'b11) begin
      err_cnt++; $display("FAIL run_active: en=%b rem=%h busy=%b want 11/0/11", clk_en_o, remaining_o, busy_o);
    end
    brk_i = 2'b10;
    tick();
    brk_i = 2'b00;
    vec_cnt++;
    if (clk_en_o !== 2'b01 || done_o !== 2'b10 || brk_hit_o !== 2'b10) begin
      err_cnt++; $display("FAIL brk_halt: en=%b done=%b hit=%b want 01/10/10", clk_en_o, done_o, brk_hit_o);
    end
    vec_cnt++;
    if (cycles_o[2*TS_W-1:TS_W] !== 8'd10) begin
      err_cnt++; $display("FAIL brk_cycles: got %0d want 10", cycles_o[2*TS_W-1:TS_W]);
    end
    tick(); tick();
    send_cmd(2'b01, 2'd0, 16'd0);
    vec_cnt++;
    if (clk_en_o !== 2'b00 || done_o !== 2'b01 || brk_hit_o !== 2'b10) begin
      err_cnt++; $display("FAIL run_stop: en=%b done=%b hit=%b want 00/01/10", clk_en_o, done_o, brk_hit_o);
    end
    send_cmd(2'b10, 2'd0, 16'd0);
    vec_cnt++;
    if (brk_hit_o !== 2'b00 || done_o !== 2'b00) begin
      err_cnt++; $display("FAIL stop_idle: hit=%b done=%b want 00/00", brk_hit_o, done_o);
    end
  endtask

  task automatic test_misc();
    brk_i = 2'b11;
    tick();
    brk_i = 2'b00;
    vec_cnt++;
    if (done_o !== 2'b00 || brk_hit_o !== 2'b00 || clk_en_o !== 2'b00) begin
      err_cnt++; $display("FAIL brk_idle: done=%b hit=%b en=%b want 00", done_o, brk_hit_o, clk_en_o);
    end
    brk_i = 2'b01;
    send_cmd(2'b01, 2'd2, 16'd0);
    brk_i = 2'b00;
    vec_cnt++;
    if (clk_en_o !== 2'b01 || brk_hit_o !== 2'b00 || done_o !== 2'b00) begin
      err_cnt++; $display("FAIL cmd_beats_brk: en=%b hit=%b done=%b want 01/00/00", clk_en_o, brk_hit_o, done_o);
    end
    send_cmd(2'b01, 2'd0, 16'd0);
    send_cmd(2'b00, 2'd1, 16'd4);
    vec_cnt++;
    if (clk_en_o !== 2'b00 || err_o !== 1'b0 || cmd_ready !== 1'b1) begin
      err_cnt++; $display("FAIL mask_zero: en=%b err=%b ready=%b want 00/0/1", clk_en_o, err_o, cmd_ready);
    end
  endtask

  task automatic test_err();
    send_cmd(2'b11, 2'd1, 16'd0);
    vec_cnt++;
    if (err_o !== 1'b1 || clk_en_o !== 2'b00 || busy_o !== 2'b00) begin
      err_cnt++; $display("FAIL step_zero: err=%b en=%b busy=%b want 1/00/00", err_o, clk_en_o, busy_o);
    end
    tick();
    vec_cnt++;
    if (err_o !== 1'b1) begin err_cnt++; $display("FAIL err_sticky: got %b want 1", err_o); end
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    vec_cnt++;
    if (err_o !== 1'b0) begin err_cnt++; $display("FAIL err_clear: got %b want 0", err_o); end
    err_clr_i = 1'b1;
    send_cmd(2'b01, 2'd1, 16'd0);
    err_clr_i = 1'b0;
    vec_cnt++;
    if (err_o !== 1'b1) begin err_cnt++; $display("FAIL err_set_beats_clr: got %b want 1", err_o); end
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
  endtask

  task automatic test_wrap();
    int n;
    send_cmd(2'b01, 2'd3, 16'd0);
    vec_cnt++;
    if (cycles_o[TS_W-1:0] !== 8'd0) begin err_cnt++; $display("FAIL clr_cyc: got %0d want 0", cycles_o[TS_W-1:0]); end
    send_cmd(2'b01, 2'd1, 16'd255);
    n = 0;
    while (done_o[0] !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    vec_cnt++;
    if (done_o[0] !== 1'b1 || cycles_o[TS_W-1:0] !== 8'd255) begin
      err_cnt++; $display("FAIL wrap_prefill: done=%b cyc=%0d want 1/255", done_o[0], cycles_o[TS_W-1:0]);
    end
    cyc_exp_q.push_back(8'd255); cyc_exp_q.push_back(8'd0); cyc_exp_q.push_back(8'd1);
    send_cmd(2'b01, 2'd1, 16'd2);
    for (int k = 0; k < 3; k++) begin
      exp_cyc = cyc_exp_q.pop_front();
      vec_cnt++;
      if (cycles_o[TS_W-1:0] !== exp_cyc) begin
        err_cnt++; $display("FAIL wrap k=%0d: got %0d want %0d", k, cycles_o[TS_W-1:0], exp_cyc);
      end
      if (k < 2) tick();
    end
    send_cmd(2'b01, 2'd2, 16'd0);
    tick(); tick();
    send_cmd(2'b01, 2'd3, 16'd0);
    vec_cnt++;
    if (cycles_o[TS_W-1:0] !== 8'd0 || clk_en_o[0] !== 1'b1) begin
      err_cnt++; $display("FAIL clr_vs_inc: cyc=%0d en=%b want 0/1", cycles_o[TS_W-1:0], clk_en_o[0]);
    end
    tick();
    vec_cnt++;
    if (cycles_o[TS_W-1:0] !== 8'd1) begin err_cnt++; $display("FAIL clr_then_inc: got %0d want 1", cycles_o[TS_W-1:0]); end
    send_cmd(2'b01, 2'd0, 16'd0);
    tick();
  endtask

  task automatic test_reset_mid_run();
    send_cmd(2'b01, 2'd1, 16'd0);
    send_cmd(2'b11, 2'd2, 16'd0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    vec_cnt++;
    if ({clk_en_o, busy_o, done_o, brk_hit_o, err_o, cmd_ready} !== '0) begin
      err_cnt++; $display("FAIL midrun_rst_flags: got %b want 0", {clk_en_o, busy_o, done_o, brk_hit_o, err_o, cmd_ready});
    end
    vec_cnt++;
    if ({remaining_o, cycles_o} !== '0) begin
      err_cnt++; $display("FAIL midrun_rst_counts: got %h want 0", {remaining_o, cycles_o});
    end
    rst = 1'b0;
    tick();
    vec_cnt++;
    if (cmd_ready !== 1'b1 || done_o !== 2'b00 || clk_en_o !== 2'b00) begin
      err_cnt++; $display("FAIL midrun_release: ready=%b done=%b en=%b want 1/00/00", cmd_ready, done_o, clk_en_o);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_ch_mask = '0; cmd_op = '0; cmd_count = '0;
    brk_i = '0; err_clr_i = 1'b0;
    test_reset();
    test_step();
    test_chain();
    test_run_brk();
    test_misc();
    test_err();
    test_wrap();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
